gpio_defaults_scanner: RTL and testbench



---
 rtl/gpio_scan_pkg.sv | 19 +
 rtl/gpio_scan_idx_seq.sv | 43 ++++
 rtl/gpio_defaults_scanner.sv | 164 ++++++++++++++++
 tb/tb_gpio_defaults_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_scan_pkg.sv
// Shared types and constants for the GPIO defaults scanner.
package gpio_scan_pkg;

    localparam int unsigned DEF_NUM_GPIO = 38;
    localparam int unsigned DEF_CFG_W    = 13;
    localparam int unsigned DEF_REV_W    = 32;
    localparam int unsigned DEF_IDX_W    = 6;

    localparam logic REC_KIND_PAD = 1'b0;
    localparam logic REC_KIND_REV = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StRev,
        StFin
    } scan_state_e;

endpackage

// File: rtl/gpio_scan_idx_seq.sv
// Pad index counter: reports the skip bit and last-pad flag of the current index.
module gpio_scan_idx_seq
    import gpio_scan_pkg::*;
#(
    parameter int unsigned NUM_GPIO = DEF_NUM_GPIO,
    parameter int unsigned IDX_W    = DEF_IDX_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                advance_i,
    input  logic [NUM_GPIO-1:0] skip_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                skip_o,
    output logic                last_o
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_GPIO - 1);

    logic [IDX_W-1:0] idx_q, idx_d, base;

    // clear acts in the same cycle so the launch cycle can already work on pad 0
    always_comb begin
        base  = clear_i ? '0 : idx_q;
        idx_d = base;
        if (advance_i) begin
            idx_d = (base == LastIdx) ? '0 : base + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = base;
    assign skip_o = skip_i[base];
    assign last_o = (base == LastIdx);

endmodule

// File: rtl/gpio_defaults_scanner.sv
// Snapshots GPIO default words and mask revision, then streams one record per pad plus revision.
module gpio_defaults_scanner
    import gpio_scan_pkg::*;
#(
    parameter int unsigned NUM_GPIO = DEF_NUM_GPIO,
    parameter int unsigned CFG_W    = DEF_CFG_W,
    parameter int unsigned REV_W    = DEF_REV_W,
    parameter int unsigned IDX_W    = DEF_IDX_W
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      start,
    input  logic [NUM_GPIO-1:0]       skip_mask,
    input  logic [NUM_GPIO*CFG_W-1:0] gpio_defaults_in,
    input  logic [NUM_GPIO*CFG_W-1:0] expect_in,
    input  logic [REV_W-1:0]          mask_rev,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic                      rec_kind,
    output logic [IDX_W-1:0]          rec_index,
    output logic [REV_W-1:0]          rec_data,
    output logic                      rec_mismatch,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W:0]            mismatch_count
);

    scan_state_e state_q, state_d;

    logic [NUM_GPIO*CFG_W-1:0] snap_cfg_q, snap_exp_q, cur_cfg, cur_exp;
    logic [NUM_GPIO-1:0]       snap_skip_q, cur_skip_vec;
    logic [REV_W-1:0]          snap_rev_q;

    logic             rec_valid_q, rec_valid_d, rec_kind_q, rec_kind_d;
    logic [IDX_W-1:0] rec_index_q, rec_index_d;
    logic [REV_W-1:0] rec_data_q, rec_data_d;
    logic             rec_mismatch_q, rec_mismatch_d;
    logic [IDX_W:0]   mcnt_q, mcnt_d;

    logic             launch, advance, cur_skip, idx_last, hs, can_load, pad_step;
    logic [IDX_W-1:0] idx;
    logic [CFG_W-1:0] cur_word, cur_expect;

    // In the launch cycle the snapshot is not loaded yet, so pad 0 is taken from the live inputs.
    assign launch       = (state_q == StIdle) && start;
    assign cur_cfg      = launch ? gpio_defaults_in : snap_cfg_q;
    assign cur_exp      = launch ? expect_in : snap_exp_q;
    assign cur_skip_vec = launch ? skip_mask : snap_skip_q;
    assign cur_word     = cur_cfg[CFG_W*idx +: CFG_W];
    assign cur_expect   = cur_exp[CFG_W*idx +: CFG_W];

    gpio_scan_idx_seq #(
        .NUM_GPIO (NUM_GPIO),
        .IDX_W    (IDX_W)
    ) u_idx_seq (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (launch),
        .advance_i (advance),
        .skip_i    (cur_skip_vec),
        .idx_o     (idx),
        .skip_o    (cur_skip),
        .last_o    (idx_last)
    );

    always_comb begin
        state_d        = state_q;
        rec_valid_d    = rec_valid_q;
        rec_kind_d     = rec_kind_q;
        rec_index_d    = rec_index_q;
        rec_data_d     = rec_data_q;
        rec_mismatch_d = rec_mismatch_q;
        mcnt_d         = mcnt_q;
        advance        = 1'b0;
        pad_step       = 1'b0;
        hs             = rec_valid_q && rec_ready;
        can_load       = !rec_valid_q || hs;

        if (hs) begin
            rec_valid_d = 1'b0;
            if (rec_mismatch_q && (mcnt_q != '1)) begin
                mcnt_d = mcnt_q + (IDX_W+1)'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcnt_d   = '0;
                    state_d  = StScan;
                    pad_step = 1'b1;
                end
            end
            StScan: pad_step = 1'b1;
            StRev: begin
                if (rec_valid_q && (rec_kind_q == REC_KIND_REV)) begin
                    if (hs) state_d = StFin;
                end else if (can_load) begin
                    rec_valid_d    = 1'b1;
                    rec_kind_d     = REC_KIND_REV;
                    rec_index_d    = '0;
                    rec_data_d     = snap_rev_q;
                    rec_mismatch_d = 1'b0;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (pad_step) begin
            if (cur_skip) begin
                advance = 1'b1;
            end else if (can_load) begin
                advance        = 1'b1;
                rec_valid_d    = 1'b1;
                rec_kind_d     = REC_KIND_PAD;
                rec_index_d    = idx;
                rec_data_d     = REV_W'(cur_word);
                rec_mismatch_d = (cur_word != cur_expect);
            end
            if (advance && idx_last) state_d = StRev;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q        <= StIdle;
            snap_cfg_q     <= '0;
            snap_exp_q     <= '0;
            snap_skip_q    <= '0;
            snap_rev_q     <= '0;
            rec_valid_q    <= 1'b0;
            rec_kind_q     <= 1'b0;
            rec_index_q    <= '0;
            rec_data_q     <= '0;
            rec_mismatch_q <= 1'b0;
            mcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            rec_valid_q    <= rec_valid_d;
            rec_kind_q     <= rec_kind_d;
            rec_index_q    <= rec_index_d;
            rec_data_q     <= rec_data_d;
            rec_mismatch_q <= rec_mismatch_d;
            mcnt_q         <= mcnt_d;
            if (launch) begin
                snap_cfg_q  <= gpio_defaults_in;
                snap_exp_q  <= expect_in;
                snap_skip_q <= skip_mask;
                snap_rev_q  <= mask_rev;
            end
        end
    end

    assign rec_valid      = rec_valid_q;
    assign rec_kind       = rec_kind_q;
    assign rec_index      = rec_index_q;
    assign rec_data       = rec_data_q;
    assign rec_mismatch   = rec_mismatch_q;
    assign mismatch_count = mcnt_q;
    assign busy           = (state_q == StScan) || (state_q == StRev);
    assign done           = (state_q == StFin);

endmodule

// File: tb/tb_gpio_defaults_scanner.sv
// Randomised bench for gpio_defaults_scanner against a record-list reference model.
module tb_gpio_defaults_scanner;

    localparam int NG = 38;
    localparam int CW = 13;
    localparam int RW = 32;
    localparam int IW = 6;

    typedef struct {
        logic          kind;
        logic [IW-1:0] idx;
        logic [RW-1:0] data;
        logic          mm;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst, start, rec_ready;
    logic [NG-1:0]    skip;
    logic [NG*CW-1:0] cfg, expv;
    logic [RW-1:0]    rev;
    logic             rec_valid, rec_kind, rec_mismatch, busy, done;
    logic [IW-1:0]    rec_index;
    logic [RW-1:0]    rec_data;
    logic [IW:0]      mismatch_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gpio_defaults_scanner u_dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .start            (start),
        .skip_mask        (skip),
        .gpio_defaults_in (cfg),
        .expect_in        (expv),
        .mask_rev         (rev),
        .rec_valid        (rec_valid),
        .rec_ready        (rec_ready),
        .rec_kind         (rec_kind),
        .rec_index        (rec_index),
        .rec_data         (rec_data),
        .rec_mismatch     (rec_mismatch),
        .busy             (busy),
        .done             (done),
        .mismatch_count   (mismatch_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Random words with expect equal, then flip expect on roughly one pad in eight.
    task automatic rand_inputs(input int skip_pct);
        for (int i = 0; i < NG; i++) begin
            cfg[i*CW +: CW]  = CW'($urandom);
            expv[i*CW +: CW] = cfg[i*CW +: CW];
            if ($urandom_range(0, 7) == 0) expv[i*CW] = ~expv[i*CW];
            skip[i] = ($urandom_range(0, 99) < skip_pct);
        end
        rev = $urandom;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NG; i++) begin
            cfg[i*CW +: CW]  = CW'($urandom);
            expv[i*CW +: CW] = CW'($urandom);
            skip[i]          = $urandom_range(0, 1) == 1;
        end
        rev = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, rec_valid, 0);
        check_eq({tag, "_kind"}, rec_kind, 0);
        check_eq({tag, "_index"}, rec_index, 0);
        check_eq({tag, "_data"}, rec_data, 0);
        check_eq({tag, "_mm"}, rec_mismatch, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_count"}, mismatch_count, 0);
    endtask

    // rmode: 0 always ready, 1 toggling ready, 2 random ready.
    task automatic run_scan(input int rmode, input bit hold, input bit scramble);
        rec_t q[$];
        rec_t e;
        rec_t prev;
        bit have_prev = 0;
        bit fin = 0;
        bit rdy;
        int mm_exp = 0;
        int k = 0;
        logic [CW-1:0] w, x;

        for (int i = 0; i < NG; i++) begin
            if (!skip[i]) begin
                w = cfg[i*CW +: CW];
                x = expv[i*CW +: CW];
                e.kind = 1'b0; e.idx = IW'(i); e.data = RW'(w); e.mm = (w != x);
                q.push_back(e);
                if (w != x) mm_exp++;
            end
        end
        e.kind = 1'b1; e.idx = '0; e.data = rev; e.mm = 1'b0;
        q.push_back(e);

        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check_eq("busy_after_start", busy, 1);

        while (!fin && k < 400) begin
            if (scramble) scramble_inputs();
            if (have_prev) begin
                check_eq("valid_held", rec_valid, 1);
                check_eq("kind_stable", rec_kind, prev.kind);
                check_eq("index_stable", rec_index, prev.idx);
                check_eq("data_stable", rec_data, prev.data);
                check_eq("mm_stable", rec_mismatch, prev.mm);
            end
            have_prev = 0;
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? k[0] : 1'($urandom_range(0, 1));
            rec_ready = rdy;
            if (rec_valid) begin
                check_eq("record_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    if (rdy) begin
                        e = q.pop_front();
                        check_eq("rec_kind", rec_kind, e.kind);
                        check_eq("rec_index", rec_index, e.idx);
                        check_eq("rec_data", rec_data, e.data);
                        check_eq("rec_mismatch", rec_mismatch, e.mm);
                        // Under continuous ready pad i occupies slot i, revision slot NG.
                        if (rmode == 0) check_eq("rec_slot", k, e.kind ? NG : int'(e.idx));
                    end else begin
                        prev.kind = rec_kind; prev.idx = rec_index;
                        prev.data = rec_data; prev.mm = rec_mismatch;
                        have_prev = 1;
                    end
                end
            end
            if (done) begin
                fin = 1;
                check_eq("done_busy_low", busy, 0);
                check_eq("records_left", q.size(), 0);
                check_eq("mismatch_count", mismatch_count, mm_exp);
                if (rmode == 0) check_eq("done_slot", k, NG + 1);
            end
            @(posedge clk); #1;
            k++;
        end
        check_eq("scan_finished", fin, 1);
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("count_hold", mismatch_count, mm_exp);
        if (hold) begin
            @(posedge clk); #1;
            check_eq("restart_busy", busy, 1);
            start = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        rec_ready = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; rec_ready = 1'b0;
        skip = '0; cfg = '0; expv = '0; rev = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        // Idle with ready high must stay quiet.
        rec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_ready_valid", rec_valid, 0);
        rec_ready = 1'b0;

        // Ascending words, nothing skipped.
        for (int i = 0; i < NG; i++) begin
            cfg[i*CW +: CW]  = CW'(i + 1);
            expv[i*CW +: CW] = CW'(i + 1);
        end
        skip = '0;
        rev  = $urandom;
        run_scan(0, 0, 0);

        // Pads 14..24 skipped.
        rand_inputs(0);
        for (int i = 14; i <= 24; i++) skip[i] = 1'b1;
        run_scan(0, 0, 0);

        // Mismatches at 5 and 37 with toggling ready.
        rand_inputs(0);
        for (int i = 0; i < NG; i++) expv[i*CW +: CW] = cfg[i*CW +: CW];
        expv[5*CW +: CW]  = ~cfg[5*CW +: CW];
        expv[37*CW +: CW] = cfg[37*CW +: CW] ^ CW'(1);
        run_scan(1, 0, 0);

        // Inputs scrambled every cycle after launch.
        rand_inputs(20);
        run_scan(2, 0, 1);

        // Reset while record 10 is stalled.
        rand_inputs(0);
        for (int i = 0; i < NG; i++) expv[i*CW +: CW] = cfg[i*CW +: CW];
        expv[3*CW] = ~expv[3*CW];
        start = 1'b1;
        rec_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(rec_valid && rec_index == IW'(10)) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        rec_ready = 1'b0;
        check_eq("stall_reached_at", k, 10);
        @(posedge clk); #1;
        check_eq("stall_index", rec_index, 10);
        check_eq("pre_reset_count", mismatch_count, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("mid_reset");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("post_reset_done", done, 0);
            check_eq("post_reset_valid", rec_valid, 0);
        end
        run_scan(0, 0, 0);

        // All pads skipped with start held high throughout.
        rand_inputs(0);
        skip = '1;
        run_scan(0, 1, 0);

        // Random scans.
        for (int r = 0; r < 4; r++) begin
            rand_inputs(25);
            run_scan(2, 0, r % 2 == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
